// File: rtl/bus_mem_slave_if.sv
// Bus bundle between a granted master and bus_mem_slave.
//   bus_active   : master owns the bus this cycle
//   bus_ctrl_in  : [4:2] burst code, [1] write, [0] master wait
//   bus_data_in  : address in the address phase, write data in beats
//   bus_ctrl_out : [0] slave wait, remaining bits 0
//   bus_data_out : read data, 0 when bus_data_oe is low
//   bus_data_oe  : slave drives bus_data_out this cycle
interface bus_mem_slave_if #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CWIDTH = 8
);
  logic              bus_active;
  logic [CWIDTH-1:0] bus_ctrl_in;
  logic [DWIDTH-1:0] bus_data_in;
  logic [CWIDTH-1:0] bus_ctrl_out;
  logic [DWIDTH-1:0] bus_data_out;
  logic              bus_data_oe;

  modport master (
    output bus_active, bus_ctrl_in, bus_data_in,
    input  bus_ctrl_out, bus_data_out, bus_data_oe
  );

  modport slave (
    input  bus_active, bus_ctrl_in, bus_data_in,
    output bus_ctrl_out, bus_data_out, bus_data_oe
  );
endinterface

// File: rtl/bus_mem_slave.sv
// Memory-mapped bus slave: 2^DEPTH_LOG2 words at BASE_ADDR, single and
// burst (1/2/4/8 beat) reads and writes, WAIT_CYCLES wait states before
// the first beat, wrap-around word pointer, abort on bus_active drop.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of bus_mem_slave_if
//   busy  : high whenever the FSM is not in IDLE
module bus_mem_slave #(
  parameter int unsigned       DWIDTH      = 32,
  parameter int unsigned       CWIDTH      = 8,
  parameter int unsigned       DEPTH_LOG2  = 8,
  parameter logic [DWIDTH-1:0] BASE_ADDR   = 'h0000_1000,
  parameter int unsigned       WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  bus_mem_slave_if.slave   bus,
  output logic             busy
);

  localparam int unsigned TAG_LO    = DEPTH_LOG2 + 2;
  localparam int unsigned WORDS     = 1 << DEPTH_LOG2;
  localparam logic [2:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, DATA, DONE} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [2:0]            beats_q, beats_d;
  logic [2:0]            wait_q, wait_d;
  logic                  wr_q, wr_d;
  logic                  armed_q, armed_d;

  logic                  hit;
  logic                  slave_wait;
  logic                  oe;
  logic                  we;
  logic [DWIDTH-1:0]     mem [WORDS];

  // Master wait and the upper control bits carry no meaning for this slave.
  logic unused_ctrl;
  assign unused_ctrl = ^{bus.bus_ctrl_in[CWIDTH-1:5], bus.bus_ctrl_in[0]};

  // Remaining beats after the current one, from the burst code.
  function automatic logic [2:0] burst_last(input logic [2:0] code);
    case (code)
      3'b001:  burst_last = 3'd1;
      3'b010:  burst_last = 3'd3;
      3'b011:  burst_last = 3'd7;
      default: burst_last = 3'd0;
    endcase
  endfunction

  assign hit = (bus.bus_data_in[DWIDTH-1:TAG_LO] == BASE_ADDR[DWIDTH-1:TAG_LO]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      beats_q <= '0;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      armed_q <= armed_d;
    end
  end

  // armed_q blocks a new address phase after a miss until the bus has
  // gone idle, so the missed master's data beats are never decoded as
  // addresses.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    beats_d    = beats_q;
    wait_d     = wait_q;
    wr_d       = wr_q;
    armed_d    = armed_q;
    slave_wait = 1'b0;
    oe         = 1'b0;
    we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.bus_active) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          if (hit) begin
            ptr_d   = bus.bus_data_in[TAG_LO-1:2];
            wr_d    = bus.bus_ctrl_in[1];
            beats_d = burst_last(bus.bus_ctrl_in[4:2]);
            wait_d  = WAIT_LAST;
            state_d = (WAIT_CYCLES > 0) ? WAIT : DATA;
          end else begin
            armed_d = 1'b0;
          end
        end
      end
      WAIT: begin
        slave_wait = 1'b1;
        if (!bus.bus_active) begin
          state_d = IDLE;
        end else if (wait_q == 3'd0) begin
          state_d = DATA;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      DATA: begin
        if (!bus.bus_active) begin
          state_d = IDLE;
        end else begin
          oe    = !wr_q;
          we    = wr_q;
          ptr_d = ptr_q + 1'b1;
          if (beats_q == 3'd0) begin
            state_d = DONE;
          end else begin
            beats_d = beats_q - 3'd1;
          end
        end
      end
      DONE: begin
        if (!bus.bus_active) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr_q] <= bus.bus_data_in;
    end
  end

  assign bus.bus_ctrl_out = {{(CWIDTH-1){1'b0}}, slave_wait};
  assign bus.bus_data_oe  = oe;
  assign bus.bus_data_out = oe ? mem[ptr_q] : '0;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_bus_mem_slave.sv
module tb_bus_mem_slave;
  logic clk = 1'b0;
  logic reset;
  logic busy;

  bus_mem_slave_if #(.DWIDTH(32), .CWIDTH(8)) bus ();

  bus_mem_slave #(
    .DWIDTH(32), .CWIDTH(8), .DEPTH_LOG2(8), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wdat [8];
  logic [7:0]  obs_ctrl [16];
  logic        obs_oe   [16];
  logic [31:0] obs_dout [16];
  logic        obs_busy [16];

  // Cycle 0 is the address phase; the master holds bus_active through the
  // DONE cycle, drops it for one cycle, then one more idle cycle is seen.
  task automatic run_txn(input logic [31:0] addr, input logic [7:0] ctrl,
                         input int nbeats, input int abort_at);
    int total;
    total = nbeats + 6;
    for (int c = 0; c < total; c++) begin
      bus.bus_ctrl_in = ctrl;
      if (c == 0) begin
        bus.bus_active  = 1'b1;
        bus.bus_data_in = addr;
      end else begin
        bus.bus_active  = (c <= nbeats + 3) && !(abort_at >= 0 && c >= abort_at);
        bus.bus_data_in = (c >= 3 && c < 11) ? wdat[c-3] : 32'h0;
      end
      @(negedge clk);
      obs_ctrl[c] = bus.bus_ctrl_out;
      obs_oe[c]   = bus.bus_data_oe;
      obs_dout[c] = bus.bus_data_out;
      obs_busy[c] = busy;
      @(posedge clk); #1;
    end
    bus.bus_active  = 1'b0;
    bus.bus_data_in = '0;
    bus.bus_ctrl_in = '0;
  endtask

  task automatic test_reset;
    bus.bus_active = 1'b0; bus.bus_ctrl_in = '0; bus.bus_data_in = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset.busy got %b want 0", busy); end
    n_cmp++; if (bus.bus_data_oe !== 1'b0) begin n_err++; $display("FAIL reset.oe got %b want 0", bus.bus_data_oe); end
    n_cmp++; if (bus.bus_ctrl_out !== 8'h00) begin n_err++; $display("FAIL reset.ctrl got %h want 00", bus.bus_ctrl_out); end
    n_cmp++; if (bus.bus_data_out !== 32'h0) begin n_err++; $display("FAIL reset.dout got %h want 0", bus.bus_data_out); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_burst8_wrap_write;
    for (int k = 0; k < 8; k++) wdat[k] = 32'hA000_0000 + k;
    run_txn(32'h0000_13F8, 8'h0E, 8, -1);
    for (int c = 0; c < 14; c++) begin
      automatic logic [7:0] ec = (c == 1 || c == 2) ? 8'h01 : 8'h00;
      automatic logic       eb = (c >= 1 && c <= 12);
      n_cmp++; if (obs_ctrl[c] !== ec) begin n_err++; $display("FAIL burst8_wr.ctrl c%0d got %h want %h", c, obs_ctrl[c], ec); end
      n_cmp++; if (obs_busy[c] !== eb) begin n_err++; $display("FAIL burst8_wr.busy c%0d got %b want %b", c, obs_busy[c], eb); end
      n_cmp++; if (obs_oe[c] !== 1'b0) begin n_err++; $display("FAIL burst8_wr.oe c%0d got %b want 0", c, obs_oe[c]); end
    end
  endtask

  task automatic test_single_write;
    for (int k = 0; k < 8; k++) wdat[k] = 32'h0;
    wdat[0] = 32'hDEAD_BEEF;
    run_txn(32'h0000_1004, 8'h02, 1, -1);
    for (int c = 0; c < 7; c++) begin
      automatic logic [7:0] ec = (c == 1 || c == 2) ? 8'h01 : 8'h00;
      automatic logic       eb = (c >= 1 && c <= 5);
      n_cmp++; if (obs_ctrl[c] !== ec) begin n_err++; $display("FAIL single_wr.ctrl c%0d got %h want %h", c, obs_ctrl[c], ec); end
      n_cmp++; if (obs_busy[c] !== eb) begin n_err++; $display("FAIL single_wr.busy c%0d got %b want %b", c, obs_busy[c], eb); end
      n_cmp++; if (obs_oe[c] !== 1'b0) begin n_err++; $display("FAIL single_wr.oe c%0d got %b want 0", c, obs_oe[c]); end
    end
  endtask

  task automatic test_raw_read;
    // Address bits [1:0] are ignored: 0x1007 selects word 1.
    run_txn(32'h0000_1007, 8'h00, 1, -1);
    for (int c = 0; c < 7; c++) begin
      automatic logic        eo = (c == 3);
      automatic logic [31:0] ed = eo ? 32'hDEAD_BEEF : 32'h0;
      n_cmp++; if (obs_oe[c] !== eo) begin n_err++; $display("FAIL raw_rd.oe c%0d got %b want %b", c, obs_oe[c], eo); end
      n_cmp++; if (obs_dout[c] !== ed) begin n_err++; $display("FAIL raw_rd.dout c%0d got %h want %h", c, obs_dout[c], ed); end
    end
  endtask

  task automatic test_burst4_read;
    logic [31:0] exp [4];
    exp[0] = 32'hA000_0004; exp[1] = 32'hA000_0005; exp[2] = 32'hA000_0006; exp[3] = 32'hA000_0007;
    run_txn(32'h0000_1008, 8'h08, 4, -1);
    for (int c = 0; c < 10; c++) begin
      automatic logic        eo = (c >= 3 && c <= 6);
      automatic logic [31:0] ed = eo ? exp[c-3] : 32'h0;
      automatic logic [7:0]  ec = (c == 1 || c == 2) ? 8'h01 : 8'h00;
      n_cmp++; if (obs_oe[c] !== eo) begin n_err++; $display("FAIL burst4_rd.oe c%0d got %b want %b", c, obs_oe[c], eo); end
      n_cmp++; if (obs_dout[c] !== ed) begin n_err++; $display("FAIL burst4_rd.dout c%0d got %h want %h", c, obs_dout[c], ed); end
      n_cmp++; if (obs_ctrl[c] !== ec) begin n_err++; $display("FAIL burst4_rd.ctrl c%0d got %h want %h", c, obs_ctrl[c], ec); end
    end
  endtask

  task automatic test_wrap_read;
    run_txn(32'h0000_13F8, 8'h04, 2, -1);
    for (int c = 0; c < 8; c++) begin
      automatic logic        eo = (c == 3 || c == 4);
      automatic logic [31:0] ed = (c == 3) ? 32'hA000_0000 : (c == 4) ? 32'hA000_0001 : 32'h0;
      n_cmp++; if (obs_oe[c] !== eo) begin n_err++; $display("FAIL wrap_rd.oe c%0d got %b want %b", c, obs_oe[c], eo); end
      n_cmp++; if (obs_dout[c] !== ed) begin n_err++; $display("FAIL wrap_rd.dout c%0d got %h want %h", c, obs_dout[c], ed); end
    end
    // Burst code 1xx is one beat; master wait and bits [7:5] are ignored.
    run_txn(32'h0000_1000, 8'hFD, 1, -1);
    for (int c = 0; c < 7; c++) begin
      automatic logic        eo = (c == 3);
      automatic logic [31:0] ed = eo ? 32'hA000_0002 : 32'h0;
      n_cmp++; if (obs_oe[c] !== eo) begin n_err++; $display("FAIL code1xx_rd.oe c%0d got %b want %b", c, obs_oe[c], eo); end
      n_cmp++; if (obs_dout[c] !== ed) begin n_err++; $display("FAIL code1xx_rd.dout c%0d got %h want %h", c, obs_dout[c], ed); end
    end
  endtask

  task automatic test_miss;
    // Data beats of the missed master look like an in-range address.
    for (int k = 0; k < 8; k++) wdat[k] = 32'h0000_1000;
    run_txn(32'h0000_2000, 8'h02, 1, -1);
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (obs_ctrl[c] !== 8'h00) begin n_err++; $display("FAIL miss.ctrl c%0d got %h want 00", c, obs_ctrl[c]); end
      n_cmp++; if (obs_busy[c] !== 1'b0) begin n_err++; $display("FAIL miss.busy c%0d got %b want 0", c, obs_busy[c]); end
      n_cmp++; if (obs_oe[c] !== 1'b0) begin n_err++; $display("FAIL miss.oe c%0d got %b want 0", c, obs_oe[c]); end
    end
    run_txn(32'h0000_1000, 8'h00, 1, -1);
    n_cmp++; if (obs_dout[3] !== 32'hA000_0002) begin n_err++; $display("FAIL miss.word0 got %h want a0000002", obs_dout[3]); end
  endtask

  task automatic test_abort;
    for (int k = 0; k < 8; k++) wdat[k] = 32'hFFFF_FFFF;
    run_txn(32'h0000_1010, 8'h02, 1, 2);
    for (int c = 0; c < 7; c++) begin
      automatic logic eb = (c == 1 || c == 2);
      n_cmp++; if (obs_busy[c] !== eb) begin n_err++; $display("FAIL abort_wait.busy c%0d got %b want %b", c, obs_busy[c], eb); end
      n_cmp++; if (obs_oe[c] !== 1'b0) begin n_err++; $display("FAIL abort_wait.oe c%0d got %b want 0", c, obs_oe[c]); end
    end
    run_txn(32'h0000_1014, 8'h06, 2, 3);
    for (int c = 0; c < 8; c++) begin
      automatic logic eb = (c >= 1 && c <= 3);
      n_cmp++; if (obs_busy[c] !== eb) begin n_err++; $display("FAIL abort_data.busy c%0d got %b want %b", c, obs_busy[c], eb); end
      n_cmp++; if (obs_oe[c] !== 1'b0) begin n_err++; $display("FAIL abort_data.oe c%0d got %b want 0", c, obs_oe[c]); end
    end
    run_txn(32'h0000_1010, 8'h04, 2, -1);
    n_cmp++; if (obs_dout[3] !== 32'hA000_0006) begin n_err++; $display("FAIL abort.word4 got %h want a0000006", obs_dout[3]); end
    n_cmp++; if (obs_dout[4] !== 32'hA000_0007) begin n_err++; $display("FAIL abort.word5 got %h want a0000007", obs_dout[4]); end
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] exp [4];
    for (int k = 0; k < 4; k++) wdat[k] = 32'hC000_0000 + k;
    run_txn(32'h0000_1020, 8'h0A, 4, -1);
    for (int k = 0; k < 4; k++) wdat[k] = 32'hB000_0000 + k;
    for (int c = 0; c < 5; c++) begin
      bus.bus_active  = 1'b1;
      bus.bus_ctrl_in = 8'h0A;
      bus.bus_data_in = (c == 0) ? 32'h0000_1020 : (c >= 3) ? wdat[c-3] : 32'h0;
      @(posedge clk); #1;
    end
    bus.bus_data_in = wdat[2];
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid.busy got %b want 0", busy); end
    n_cmp++; if (bus.bus_data_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid.oe got %b want 0", bus.bus_data_oe); end
    n_cmp++; if (bus.bus_ctrl_out !== 8'h00) begin n_err++; $display("FAIL rst_mid.ctrl got %h want 00", bus.bus_ctrl_out); end
    n_cmp++; if (bus.bus_data_out !== 32'h0) begin n_err++; $display("FAIL rst_mid.dout got %h want 0", bus.bus_data_out); end
    @(posedge clk); #1;
    bus.bus_data_in = wdat[3];
    @(posedge clk); #1;
    reset = 1'b1;
    // bus_active stays high: the first edge after release is an address phase.
    exp[0] = 32'hB000_0000; exp[1] = 32'hB000_0001; exp[2] = 32'hC000_0002; exp[3] = 32'hC000_0003;
    run_txn(32'h0000_1020, 8'h08, 4, -1);
    for (int c = 0; c < 10; c++) begin
      automatic logic        eo = (c >= 3 && c <= 6);
      automatic logic [31:0] ed = eo ? exp[c-3] : 32'h0;
      n_cmp++; if (obs_oe[c] !== eo) begin n_err++; $display("FAIL rst_mid_rd.oe c%0d got %b want %b", c, obs_oe[c], eo); end
      n_cmp++; if (obs_dout[c] !== ed) begin n_err++; $display("FAIL rst_mid_rd.dout c%0d got %h want %h", c, obs_dout[c], ed); end
    end
  endtask

  initial begin
    test_reset();
    test_burst8_wrap_write();
    test_single_write();
    test_raw_read();
    test_burst4_read();
    test_wrap_read();
    test_miss();
    test_abort();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
